// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two data-memory requesters, the arbiter and the RAM.
// The slave modport is the arbiter's view. The master modport is the view of
// everything around it: the core, the aux master and the RAM.
interface dmem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) ();

  localparam int unsigned BE_W = DATA_W / 8;

  // Core load/store unit
  logic              c_req;
  logic              c_we;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic [BE_W-1:0]   c_be;
  logic              c_gnt;
  logic              c_rvalid;
  logic [DATA_W-1:0] c_rdata;

  // Auxiliary master (debug loader / DMA)
  logic              a_req;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic [BE_W-1:0]   a_be;
  logic              a_gnt;
  logic              a_rvalid;
  logic [DATA_W-1:0] a_rdata;

  // Single-port synchronous RAM
  logic              m_en;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [BE_W-1:0]   m_be;
  logic [DATA_W-1:0] m_rdata;

  modport slave (
    input  c_req, c_we, c_addr, c_wdata, c_be,
    output c_gnt, c_rvalid, c_rdata,
    input  a_req, a_we, a_addr, a_wdata, a_be,
    output a_gnt, a_rvalid, a_rdata,
    output m_en, m_we, m_addr, m_wdata, m_be,
    input  m_rdata
  );

  modport master (
    output c_req, c_we, c_addr, c_wdata, c_be,
    input  c_gnt, c_rvalid, c_rdata,
    output a_req, a_we, a_addr, a_wdata, a_be,
    input  a_gnt, a_rvalid, a_rdata,
    input  m_en, m_we, m_addr, m_wdata, m_be,
    output m_rdata
  );

endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares one single-port synchronous RAM between the core
// (fixed priority) and an auxiliary master. A starvation counter forces an aux
// grant after STARVE_MAX consecutive denied aux cycles. Read data is steered
// back to the master that issued the read one cycle after its grant, and core
// stall cycles are counted with saturation for performance measurement.
module dmem_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              Rstn,
  dmem_arbiter_if.slave     bus,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int unsigned BE_W     = DATA_W / 8;
  localparam int unsigned STARVE_W = 4;
  localparam logic [STARVE_W-1:0] StarveMax = STARVE_W'(STARVE_MAX);

  // Registered state
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                rd_pend_q, rd_pend_d;
  logic                rd_owner_q, rd_owner_d; // 0 = core, 1 = aux
  logic [CNT_W-1:0]    stall_q, stall_d;

  // Combinational grant decision
  logic force_aux;
  logic c_gnt;
  logic a_gnt;
  logic rd_granted;

  // Grant: core has priority unless aux has waited STARVE_MAX cycles.
  // Both grants are held low while reset is asserted.
  always_comb begin
    force_aux = (starve_q == StarveMax);
    a_gnt     = Rstn & bus.a_req & (force_aux | ~bus.c_req);
    c_gnt     = Rstn & bus.c_req & ~a_gnt;
  end

  assign bus.c_gnt = c_gnt;
  assign bus.a_gnt = a_gnt;

  // RAM request mux: drive the granted master's fields, all zero when idle.
  always_comb begin
    bus.m_en    = 1'b0;
    bus.m_we    = 1'b0;
    bus.m_addr  = '0;
    bus.m_wdata = '0;
    bus.m_be    = '0;
    if (c_gnt) begin
      bus.m_en    = 1'b1;
      bus.m_we    = bus.c_we;
      bus.m_addr  = bus.c_addr;
      bus.m_wdata = bus.c_wdata;
      bus.m_be    = bus.c_be;
    end else if (a_gnt) begin
      bus.m_en    = 1'b1;
      bus.m_we    = bus.a_we;
      bus.m_addr  = bus.a_addr;
      bus.m_wdata = bus.a_wdata;
      bus.m_be    = bus.a_be;
    end
  end

  // Next state for starvation, read tracking and stall counting.
  always_comb begin
    starve_d   = starve_q;
    rd_pend_d  = 1'b0;
    rd_owner_d = rd_owner_q;
    stall_d    = stall_q;

    // Count consecutive denied aux cycles; any aux grant or an aux request
    // that drops away restarts the wait.
    if (bus.a_req && !a_gnt) begin
      if (starve_q < StarveMax) begin
        starve_d = starve_q + STARVE_W'(1);
      end
    end else begin
      starve_d = '0;
    end

    // Remember who owns the RAM read data that appears next cycle.
    rd_granted = (c_gnt & ~bus.c_we) | (a_gnt & ~bus.a_we);
    if (rd_granted) begin
      rd_pend_d  = 1'b1;
      rd_owner_d = a_gnt;
    end

    if (bus.c_req && !c_gnt && !(&stall_q)) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!Rstn) begin
      starve_q   <= '0;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= 1'b0;
      stall_q    <= '0;
    end else begin
      starve_q   <= starve_d;
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
      stall_q    <= stall_d;
    end
  end

  // Read return: only the owner of the pending read sees valid data.
  always_comb begin
    bus.c_rvalid = rd_pend_q & ~rd_owner_q;
    bus.a_rvalid = rd_pend_q & rd_owner_q;
    bus.c_rdata  = bus.c_rvalid ? bus.m_rdata : '0;
    bus.a_rdata  = bus.a_rvalid ? bus.m_rdata : '0;
  end

  assign stall_cnt = stall_q;

  // Sanity properties on the arbitration outcome.
  a_one_grant: assert property (@(posedge clk) !(c_gnt && a_gnt));
  a_one_rvalid: assert property (@(posedge clk) !(bus.c_rvalid && bus.a_rvalid));
  a_starve_bound: assert property (@(posedge clk) starve_q <= StarveMax);

  logic unused_be;
  assign unused_be = ^{BE_W'(0)};

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small byte-enabled RAM model.
module tb_dmem_arbiter;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 16;

  logic             clk;
  logic             Rstn;
  logic [CNT_W-1:0] stall_cnt;

  dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  dmem_arbiter #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .STARVE_MAX(4),
    .CNT_W     (CNT_W)
  ) u_dut (
    .clk      (clk),
    .Rstn     (Rstn),
    .bus      (bus),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: one-cycle read latency, byte-enabled writes.
  logic [31:0] mem [0:63];
  always @(posedge clk) begin
    if (bus.m_en) begin
      if (bus.m_we) begin
        for (int b = 0; b < 4; b++) begin
          if (bus.m_be[b]) mem[bus.m_addr[7:2]][8*b +: 8] <= bus.m_wdata[8*b +: 8];
        end
      end else begin
        bus.m_rdata <= mem[bus.m_addr[7:2]];
      end
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    bus.c_req = 1'b0; bus.c_we = 1'b0; bus.c_addr = '0; bus.c_wdata = '0; bus.c_be = '0;
    bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = '0; bus.a_wdata = '0; bus.a_be = '0;
  endtask

  logic prev_c, prev_a, exp_a;
  logic a_pat [0:8];

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem[0]  = 32'hA0A0_A0A0;
    mem[1]  = 32'h1111_1111;
    mem[2]  = 32'h2222_2222;
    mem[3]  = 32'h3333_3333;
    mem[4]  = 32'hDEAD_BEEF;
    bus.m_rdata = '0;
    Rstn = 1'b0;
    idle_inputs();

    // Reset held 10 cycles; requests during reset must not be granted.
    repeat (9) tick();
    bus.c_req = 1'b1;
    bus.a_req = 1'b1;
    settle();
    check("rst_c_gnt", 64'(bus.c_gnt), 64'd0);
    check("rst_a_gnt", 64'(bus.a_gnt), 64'd0);
    check("rst_m_en", 64'(bus.m_en), 64'd0);
    tick();
    idle_inputs();
    Rstn = 1'b1;
    settle();
    check("idle_c_gnt", 64'(bus.c_gnt), 64'd0);
    check("idle_a_gnt", 64'(bus.a_gnt), 64'd0);
    check("idle_m_en", 64'(bus.m_en), 64'd0);
    check("idle_c_rvalid", 64'(bus.c_rvalid), 64'd0);
    check("idle_a_rvalid", 64'(bus.a_rvalid), 64'd0);
    check("idle_stall", 64'(stall_cnt), 64'd0);
    tick();

    // Core read of 0x10.
    bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_addr = 32'h10; bus.c_be = 4'hF;
    settle();
    check("crd_c_gnt", 64'(bus.c_gnt), 64'd1);
    check("crd_m_addr", 64'(bus.m_addr), 64'h10);
    check("crd_m_we", 64'(bus.m_we), 64'd0);
    check("crd_m_en", 64'(bus.m_en), 64'd1);
    tick();
    idle_inputs();
    settle();
    check("crd_c_rvalid", 64'(bus.c_rvalid), 64'd1);
    check("crd_c_rdata", 64'(bus.c_rdata), 64'hDEAD_BEEF);
    check("crd_a_rvalid", 64'(bus.a_rvalid), 64'd0);
    check("crd_a_rdata", 64'(bus.a_rdata), 64'd0);
    tick();

    // Aux partial write to 0x20.
    bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = 32'h20;
    bus.a_wdata = 32'hCAFE_F00D; bus.a_be = 4'b0011;
    settle();
    check("awr_a_gnt", 64'(bus.a_gnt), 64'd1);
    check("awr_c_gnt", 64'(bus.c_gnt), 64'd0);
    check("awr_m_we", 64'(bus.m_we), 64'd1);
    check("awr_m_be", 64'(bus.m_be), 64'b0011);
    check("awr_m_addr", 64'(bus.m_addr), 64'h20);
    check("awr_m_wdata", 64'(bus.m_wdata), 64'hCAFE_F00D);
    tick();
    idle_inputs();
    settle();
    check("awr_a_rvalid", 64'(bus.a_rvalid), 64'd0);
    check("awr_c_rvalid", 64'(bus.c_rvalid), 64'd0);
    tick();

    // Continuous contention: core x4, aux x1, repeating.
    bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_addr = 32'h0; bus.c_be = 4'hF;
    bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 32'hC; bus.a_be = 4'hF;
    prev_c = 1'b0;
    prev_a = 1'b0;
    for (int i = 0; i < 10; i++) begin
      settle();
      exp_a = ((i % 5) == 4);
      check($sformatf("cont%0d_c_gnt", i), 64'(bus.c_gnt), 64'(!exp_a));
      check($sformatf("cont%0d_a_gnt", i), 64'(bus.a_gnt), 64'(exp_a));
      check($sformatf("cont%0d_c_rvalid", i), 64'(bus.c_rvalid), 64'(prev_c));
      check($sformatf("cont%0d_a_rvalid", i), 64'(bus.a_rvalid), 64'(prev_a));
      check($sformatf("cont%0d_c_rdata", i), 64'(bus.c_rdata),
            prev_c ? 64'hA0A0_A0A0 : 64'd0);
      check($sformatf("cont%0d_a_rdata", i), 64'(bus.a_rdata),
            prev_a ? 64'h3333_3333 : 64'd0);
      prev_c = !exp_a;
      prev_a = exp_a;
      tick();
    end
    idle_inputs();
    settle();
    check("cont_stall", 64'(stall_cnt), 64'd2);
    tick();

    // Aux request drops mid-wait: the starvation count restarts.
    a_pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    bus.c_req = 1'b1; bus.c_addr = 32'h0; bus.c_be = 4'hF;
    bus.a_addr = 32'hC; bus.a_be = 4'hF;
    for (int i = 0; i < 9; i++) begin
      bus.a_req = a_pat[i];
      settle();
      check($sformatf("drop%0d_a_gnt", i), 64'(bus.a_gnt), 64'(i == 8));
      check($sformatf("drop%0d_c_gnt", i), 64'(bus.c_gnt), 64'(i != 8));
      tick();
    end
    idle_inputs();
    settle();
    check("drop_stall", 64'(stall_cnt), 64'd3);
    tick();

    // Core read granted, then reset at the closing edge: no rvalid afterwards.
    bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_addr = 32'h10; bus.c_be = 4'hF;
    settle();
    check("rstrd_c_gnt", 64'(bus.c_gnt), 64'd1);
    Rstn = 1'b0;
    tick();
    idle_inputs();
    Rstn = 1'b1;
    settle();
    check("rstrd_c_rvalid", 64'(bus.c_rvalid), 64'd0);
    check("rstrd_c_rdata", 64'(bus.c_rdata), 64'd0);
    check("rstrd_stall", 64'(stall_cnt), 64'd0);
    tick();
    check("rstrd_c_rvalid2", 64'(bus.c_rvalid), 64'd0);

    // Alternating core/aux reads: responses must not cross.
    bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_addr = 32'h4; bus.c_be = 4'hF;
    settle();
    check("alt_c_gnt", 64'(bus.c_gnt), 64'd1);
    check("alt_c_m_addr", 64'(bus.m_addr), 64'h4);
    tick();
    bus.c_req = 1'b0;
    bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 32'h8; bus.a_be = 4'hF;
    settle();
    check("alt_a_gnt", 64'(bus.a_gnt), 64'd1);
    check("alt_a_m_addr", 64'(bus.m_addr), 64'h8);
    check("alt1_c_rvalid", 64'(bus.c_rvalid), 64'd1);
    check("alt1_c_rdata", 64'(bus.c_rdata), 64'h1111_1111);
    check("alt1_a_rvalid", 64'(bus.a_rvalid), 64'd0);
    tick();
    bus.a_req = 1'b0;
    bus.c_req = 1'b1;
    settle();
    check("alt2_a_rvalid", 64'(bus.a_rvalid), 64'd1);
    check("alt2_a_rdata", 64'(bus.a_rdata), 64'h2222_2222);
    check("alt2_c_rvalid", 64'(bus.c_rvalid), 64'd0);
    check("alt2_c_rdata", 64'(bus.c_rdata), 64'd0);
    tick();
    bus.c_req = 1'b0;
    settle();
    check("alt3_c_rvalid", 64'(bus.c_rvalid), 64'd1);
    check("alt3_c_rdata", 64'(bus.c_rdata), 64'h1111_1111);
    check("alt3_a_rdata", 64'(bus.a_rdata), 64'd0);
    tick();
    check("alt4_c_rvalid", 64'(bus.c_rvalid), 64'd0);
    check("alt4_a_rvalid", 64'(bus.a_rvalid), 64'd0);

    // Read back the earlier partial write through the aux port.
    bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 32'h20; bus.a_be = 4'hF;
    settle();
    check("rb_a_gnt", 64'(bus.a_gnt), 64'd1);
    tick();
    idle_inputs();
    settle();
    check("rb_a_rvalid", 64'(bus.a_rvalid), 64'd1);
    check("rb_a_rdata", 64'(bus.a_rdata), 64'h0000_F00D);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
